sha_256_stream: RTL and testbench

- Multi-block, streaming SHA-256/SHA-224 compression engine.
- Accepts pre-padded 512-bit blocks over a valid/ready handshake and chains the hash state across blocks.
- Presents the final digest over a valid/ready output handshake.
- Round datapath is unrolled by a parameter. This replaces the fixed single-block, fixed-length hasher for long messages and back-to-back hashing.

---
 rtl/sha_256_pkg.sv | 66 ++++++
 rtl/sha_256_stream_if.sv | 23 ++
 rtl/sha_256_round.sv | 19 +
 rtl/sha_256_stream.sv | 127 ++++++++++++
 tb/tb_sha_256_stream.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sha_256_pkg.sv
// Shared SHA-256/224 constants, types and round helper functions used by the
// streaming compression engine and its round sub-module.
package sha_256_pkg;

  typedef logic [0:7][31:0] hash_t;

  typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_t;

  localparam hash_t IV_256 = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam hash_t IV_224 = {
    32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
    32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
  };

  localparam logic [31:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] ror(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] e, f, g);
    return (e & f) ^ (~e & g);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] a, b, c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return ror(x, 2) ^ ror(x, 13) ^ ror(x, 22);
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return ror(x, 6) ^ ror(x, 11) ^ ror(x, 25);
  endfunction

  function automatic logic [31:0] small_sigma0(input logic [31:0] x);
    return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] small_sigma1(input logic [31:0] x);
    return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
  endfunction

endpackage

// File: rtl/sha_256_stream_if.sv
// Block-in / digest-out handshake bundle of the streaming SHA-256 engine.
// master = block producer and digest consumer, slave = the engine.
interface sha_256_stream_if;
  logic [511:0] blk_data;
  logic         blk_valid;
  logic         blk_first;
  logic         blk_last;
  logic         blk_mode224;
  logic         blk_ready;
  logic [255:0] digest;
  logic         digest_valid;
  logic         digest_ready;

  modport master (
    output blk_data, blk_valid, blk_first, blk_last, blk_mode224, digest_ready,
    input  blk_ready, digest, digest_valid
  );

  modport slave (
    input  blk_data, blk_valid, blk_first, blk_last, blk_mode224, digest_ready,
    output blk_ready, digest, digest_valid
  );
endinterface

// File: rtl/sha_256_round.sv
// One combinational SHA-256 compression round: working vars a..h (index 0..7)
// plus W_t and K_t in, next a..h out.
module sha_256_round
  import sha_256_pkg::*;
(
  input  hash_t       st_in,
  input  logic [31:0] w_t,
  input  logic [31:0] k_t,
  output hash_t       st_out
);
  logic [31:0] t1, t2;

  always_comb begin
    t1 = st_in[7] + big_sigma1(st_in[4]) + ch(st_in[4], st_in[5], st_in[6]) + k_t + w_t;
    t2 = big_sigma0(st_in[0]) + maj(st_in[0], st_in[1], st_in[2]);
    st_out = {t1 + t2, st_in[0], st_in[1], st_in[2],
              st_in[3] + t1, st_in[4], st_in[5], st_in[6]};
  end
endmodule

// File: rtl/sha_256_stream.sv
// Streaming multi-block SHA-256/SHA-224 engine: chains H across pre-padded
// blocks, ROUNDS_PER_CYCLE rounds per clock, digest held until taken.
module sha_256_stream
  import sha_256_pkg::*;
#(
  parameter int ROUNDS_PER_CYCLE = 1
) (
  input logic             clk,
  input logic             rst,
  sha_256_stream_if.slave bus
);
  localparam int         R      = ROUNDS_PER_CYCLE;
  localparam logic [5:0] T_STEP = 6'(R);
  localparam logic [5:0] T_LAST = 6'(64 - R);

  if (!(R == 1 || R == 2 || R == 4 || R == 8)) begin : g_bad_rounds
    $error("ROUNDS_PER_CYCLE must be 1, 2, 4 or 8");
  end

  state_t             state;
  hash_t              h, work, h_sum, iv_sel;
  hash_t              chain [0:R];
  logic [0:15][31:0]  w;
  logic [0:15+R][31:0] ext;
  logic [5:0]         t;
  logic               last, mode224;
  logic               blk_ready_q, digest_valid_q;
  logic [255:0]       digest_q, digest_fmt;

  // Window words 0..R-1 feed this cycle's rounds; R new words are appended
  // so the window can slide by R. New word j may depend on new word j-2.
  function automatic logic [0:15+R][31:0] expand(input logic [0:15][31:0] win);
    logic [0:15+R][31:0] e;
    e[0:15] = win;
    for (int j = 0; j < R; j++)
      e[16+j] = small_sigma1(e[14+j]) + e[9+j] + small_sigma0(e[1+j]) + e[j];
    return e;
  endfunction

  assign ext      = expand(w);
  assign chain[0] = work;

  for (genvar g = 0; g < R; g++) begin : g_round
    sha_256_round u_round (
      .st_in  (chain[g]),
      .w_t    (ext[g]),
      .k_t    (K[t + 6'(g)]),
      .st_out (chain[g+1])
    );
  end

  assign iv_sel = bus.blk_mode224 ? IV_224 : IV_256;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    digest_fmt = '0;
    for (int i = 0; i < 8; i++) h_sum[i] = h[i] + work[i];
    if (mode224) digest_fmt = {h_sum[0:6], 32'h0};
    else         digest_fmt = h_sum;
  end

  // NOTE: sequential state is written with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      blk_ready_q    <= 1'b1;
      digest_valid_q <= 1'b0;
      digest_q       <= '0;
      h              <= IV_256;
      mode224        <= 1'b0;
      t              <= '0;
      last           <= 1'b0;
      // NOTE: window and working vars are pure datapath, but they are cleared with
      // the rest so nothing downstream ever sees X after reset.
      work           <= '0;
      w              <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.blk_valid) begin
            w    <= bus.blk_data;
            last <= bus.blk_last;
            t    <= '0;
            if (bus.blk_first) begin
              mode224 <= bus.blk_mode224;
              h       <= iv_sel;
              work    <= iv_sel;
            end else begin
              work <= h;
            end
            blk_ready_q <= 1'b0;
            state       <= ROUND;
          end
        end
        ROUND: begin
          work <= chain[R];
          w    <= ext[R +: 16];
          t    <= t + T_STEP;
          if (t == T_LAST) state <= FINAL;
        end
        FINAL: begin
          h <= h_sum;
          if (last) begin
            digest_q       <= digest_fmt;
            digest_valid_q <= 1'b1;
            state          <= DONE;
          end else begin
            blk_ready_q <= 1'b1;
            state       <= IDLE;
          end
        end
        DONE: begin
          if (bus.digest_ready) begin
            digest_valid_q <= 1'b0;
            blk_ready_q    <= 1'b1;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.blk_ready    = blk_ready_q;
  assign bus.digest_valid = digest_valid_q;
  assign bus.digest       = digest_q;
endmodule

// File: tb/tb_sha_256_stream.sv
// Scoreboard bench for sha_256_stream: four instances (1/2/4/8 rounds per cycle)
// driven by directed FIPS 180 vectors; a monitor checks digest and latency.
module tb_sha_256_stream;

  localparam logic [255:0] D_ABC  = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] D_2BLK = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;
  localparam logic [255:0] D_E224 = {224'hd14a028c_2a3a2bc9_476102bb_288234c4_15a2b01f_828ea62a_c5b3e42f, 32'h0};

  localparam logic [511:0] M_ABC  = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] M_E224 = {32'h80000000, 480'h0};
  localparam logic [511:0] M_B1   = {
    256'h61626364_62636465_63646566_64656667_65666768_66676869_6768696a_68696a6b,
    256'h696a6b6c_6a6b6c6d_6b6c6d6e_6c6d6e6f_6d6e6f70_6e6f7071_80000000_00000000};
  localparam logic [511:0] M_B2   = {480'h0, 32'h000001c0};

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [511:0] blk_data     [4];
  logic         blk_valid    [4];
  logic         blk_first    [4];
  logic         blk_last     [4];
  logic         blk_mode224  [4];
  logic         digest_ready [4];
  logic         blk_ready    [4];
  logic         digest_valid [4];
  logic [255:0] digest       [4];

  typedef struct {
    int           dut;
    logic [255:0] d;
    longint       due;
  } exp_t;

  exp_t   sb[$];
  int     tests = 0;
  int     fails = 0;
  longint cyc   = 0;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    sha_256_stream_if bus ();
    assign bus.blk_data     = blk_data[g];
    assign bus.blk_valid    = blk_valid[g];
    assign bus.blk_first    = blk_first[g];
    assign bus.blk_last     = blk_last[g];
    assign bus.blk_mode224  = blk_mode224[g];
    assign bus.digest_ready = digest_ready[g];
    assign blk_ready[g]     = bus.blk_ready;
    assign digest_valid[g]  = bus.digest_valid;
    assign digest[g]        = bus.digest;

    sha_256_stream #(.ROUNDS_PER_CYCLE(1 << g)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );
  end

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input string what);
    tests++;
    fails++;
    $display("FAIL %s: %s", name, what);
  endtask

  // Offers one block to DUT d after `gap` idle cycles; on acceptance optionally
  // queues the expected digest and the cycle its digest_valid must rise on.
  task automatic send(input int d, input logic [511:0] data, input logic first,
                      input logic last, input logic m224, input logic [255:0] exp_d,
                      input bit push, input int gap);
    int     n;
    longint k;
    exp_t   e;
    repeat (gap) @(posedge clk);
    #1;
    blk_data[d]    = data;
    blk_first[d]   = first;
    blk_last[d]    = last;
    blk_mode224[d] = m224;
    blk_valid[d]   = 1'b1;
    n = 0;
    while (!blk_ready[d] && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 300) begin
      fail_now($sformatf("accept_timeout_dut%0d", d), "blk_ready never rose");
      blk_valid[d] = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      k = cyc;
      blk_valid[d] = 1'b0;
      if (push) begin
        e.dut = d;
        e.d   = exp_d;
        e.due = k + longint'(64 >> d) + 1;
        sb.push_back(e);
      end
    end
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      fail_now(name, $sformatf("%0d expected digests never arrived", sb.size()));
      sb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: every rising digest_valid must match the head of the scoreboard.
  initial begin : monitor
    bit   prev_v [4];
    exp_t e;
    for (int g = 0; g < 4; g++) prev_v[g] = 1'b0;
    forever begin
      @(negedge clk);
      for (int g = 0; g < 4; g++) begin
        if (digest_valid[g] === 1'b1 && !prev_v[g]) begin
          if (sb.size() == 0 || sb[0].dut != g) begin
            fail_now($sformatf("spurious_valid_dut%0d", g), "got digest_valid=1 expected 0");
          end else begin
            e = sb.pop_front();
            check($sformatf("digest_dut%0d", g), digest[g], e.d);
            check_int($sformatf("latency_dut%0d", g), cyc, e.due);
          end
        end
        prev_v[g] = (digest_valid[g] === 1'b1);
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int n;
    for (int d = 0; d < 4; d++) begin
      blk_data[d]     = '0;
      blk_valid[d]    = 1'b0;
      blk_first[d]    = 1'b0;
      blk_last[d]     = 1'b0;
      blk_mode224[d]  = 1'b0;
      digest_ready[d] = 1'b1;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 4; d++) begin
      check($sformatf("reset_blk_ready_dut%0d", d), 256'(blk_ready[d]), 256'd1);
      check($sformatf("reset_digest_valid_dut%0d", d), 256'(digest_valid[d]), 256'd0);
      check($sformatf("reset_digest_dut%0d", d), digest[d], 256'd0);
    end
    #2 rst = 1'b0;

    // "abc" and the two-block message at every unroll factor
    for (int d = 0; d < 4; d++) begin
      send(d, M_ABC, 1'b1, 1'b1, 1'b0, D_ABC, 1'b1, 0);
      drain($sformatf("abc_drain_dut%0d", d));
      send(d, M_B1, 1'b1, 1'b0, 1'b0, '0, 1'b0, 0);
      send(d, M_B2, 1'b0, 1'b1, 1'b0, D_2BLK, 1'b1, 3);
      drain($sformatf("two_block_drain_dut%0d", d));
    end

    // SHA-224 empty message; digest register survives the handoff
    send(0, M_E224, 1'b1, 1'b1, 1'b1, D_E224, 1'b1, 0);
    drain("e224_drain");
    repeat (2) @(posedge clk);
    #1;
    check("digest_kept_after_handoff", digest[0], D_E224);

    // blk_first mid-message discards the partial chain
    send(0, M_B1, 1'b1, 1'b0, 1'b0, '0, 1'b0, 0);
    send(0, M_ABC, 1'b1, 1'b1, 1'b0, D_ABC, 1'b1, 0);
    drain("restart_drain");

    // blk_mode224 on a non-first block is ignored
    send(0, M_B1, 1'b1, 1'b0, 1'b0, '0, 1'b0, 0);
    send(0, M_B2, 1'b0, 1'b1, 1'b1, D_2BLK, 1'b1, 1);
    drain("mode_ignored_drain");

    // Back-pressure: digest held, offered block refused
    digest_ready[0] = 1'b0;
    send(0, M_ABC, 1'b1, 1'b1, 1'b0, D_ABC, 1'b1, 0);
    n = 0;
    while (digest_valid[0] !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) fail_now("hold_wait_valid", "digest_valid never rose");
    blk_data[0]  = M_ABC;
    blk_first[0] = 1'b1;
    blk_last[0]  = 1'b1;
    blk_valid[0] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("hold_valid_ready_%0d", i), {254'd0, digest_valid[0], blk_ready[0]}, 256'b10);
      check($sformatf("hold_digest_%0d", i), digest[0], D_ABC);
    end
    digest_ready[0] = 1'b1;
    send(0, M_ABC, 1'b1, 1'b1, 1'b0, D_ABC, 1'b1, 0);
    drain("after_hold_drain");

    // Leave the engine in SHA-224 mode, then reset in the middle of a block
    send(0, M_E224, 1'b1, 1'b1, 1'b1, D_E224, 1'b1, 0);
    drain("pre_reset_drain");
    send(0, M_ABC, 1'b1, 1'b1, 1'b0, '0, 1'b0, 0);
    repeat (30) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("abort_blk_ready", 256'(blk_ready[0]), 256'd1);
    check("abort_digest_valid", 256'(digest_valid[0]), 256'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (80) @(posedge clk);

    // Non-first block after reset chains from the SHA-256 IV
    send(0, M_ABC, 1'b0, 1'b1, 1'b1, D_ABC, 1'b1, 0);
    drain("post_reset_nonfirst_drain");
    send(0, M_ABC, 1'b1, 1'b1, 1'b0, D_ABC, 1'b1, 0);
    drain("post_reset_first_drain");

    repeat (5) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
